// File: rtl/master_read_sink_pkg.sv
// rtl/master_read_sink_pkg.sv - shared types and constants for the master read sink
// Purpose: capture FSM encoding, FIFO entry width, read-direction encoding of m_wrdn
//          and the saturating word-counter increment.
package master_read_sink_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_e;

    // One FIFO entry: {last, data[31:0]}
    localparam int ENTRY_W = 33;

    localparam logic WRDN_READ = 1'b0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sink_fifo.sv
// rtl/sink_fifo.sv - synchronous first-word-fall-through FIFO on tpram storage
// Purpose: buffers {last, data} entries; a pushed entry is visible on pop_data_o next cycle.
// Ports: clk_i, resetn_i (sync, active low); push_i/push_data_i; pop_i/pop_data_o;
//        empty_o, full_o, level_o (occupancy, extra MSB separates full from empty).
module sink_fifo
    import master_read_sink_pkg::*;
#(
    parameter int ADDR_LENGTH = 5
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic                 push_i,
    input  logic [ENTRY_W-1:0]   push_data_i,
    input  logic                 pop_i,
    output logic [ENTRY_W-1:0]   pop_data_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic [ADDR_LENGTH:0] level_o
);

    localparam int LW    = ADDR_LENGTH + 1;
    localparam int DEPTH = 1 << ADDR_LENGTH;

    logic [ADDR_LENGTH:0] wr_ptr_q, rd_ptr_q;
    logic                 wr_en, rd_en;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == LW'(DEPTH));
    assign empty_o = (level_o == '0);

    // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
    assign wr_en = push_i & (~full_o | pop_i);
    assign rd_en = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + LW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + LW'(1);
            end
        end
    end

    tpram #(
        .DW(ENTRY_W),
        .AW(ADDR_LENGTH)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[ADDR_LENGTH-1:0]),
        .wdata_i (push_data_i),
        .raddr_i (rd_ptr_q[ADDR_LENGTH-1:0]),
        .rdata_o (pop_data_o)
    );

endmodule

// File: rtl/tpram.sv
// rtl/tpram.sv - two-port RAM, synchronous write port, asynchronous read port
// Purpose: storage array for small FIFOs.
// Ports: clk_i; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o combinational read port.
module tpram #(
    parameter int DW = 33,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/master_read_sink.sv
// rtl/master_read_sink.sv - PCI master read-data sink with FWFT buffer and stream output
// Purpose: captures adio_out words of master reads, tags the final word of each transaction,
//          streams them out and throttles the core via m_ready.
// Ports: CLK, reset_n (sync, active low); PCI side adio_out, m_data, m_data_vld, m_addr_n,
//        m_wrdn, m_ready; stream side rd_data, rd_last, rd_valid, rd_ready;
//        status level, xfer_done, xfer_len, overflow.
module master_read_sink
    import master_read_sink_pkg::*;
#(
    parameter int ADDR_LENGTH = 5,
    parameter int AF_MARGIN   = 4
) (
    input  logic                 CLK,
    input  logic                 reset_n,
    input  logic [31:0]          adio_out,
    input  logic                 m_data,
    input  logic                 m_data_vld,
    input  logic                 m_addr_n,
    input  logic                 m_wrdn,
    output logic                 m_ready,
    output logic [31:0]          rd_data,
    output logic                 rd_last,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [ADDR_LENGTH:0] level,
    output logic                 xfer_done,
    output logic [15:0]          xfer_len,
    output logic                 overflow
);

    localparam int DEPTH = 1 << ADDR_LENGTH;
    localparam int FW    = ADDR_LENGTH + 2;

    state_e        state_q, state_d;
    logic          m_dataq_q;
    logic [31:0]   hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          pend_last_q, pend_last_d;
    logic          m_ready_q;
    logic          xfer_done_q, xfer_done_d;
    logic [15:0]   xfer_len_q, xfer_len_d;
    logic          overflow_q;

    logic               push;
    logic [ENTRY_W-1:0] push_data;
    logic               pop;
    logic [ENTRY_W-1:0] fifo_data;
    logic               fifo_empty, fifo_full;
    logic [ADDR_LENGTH:0] fifo_level;

    logic          m_data_fell, capture, end_xfer;
    logic [FW-1:0] free_slots;

    assign m_data_fell = m_dataq_q & ~m_data;
    assign capture     = ((state_q == S_ADDR) || (state_q == S_DATA)) && m_data_vld;
    assign end_xfer    = (state_q == S_DATA) && m_data_fell;

    // Free slots count the holding register as one extra slot.
    assign free_slots = FW'(DEPTH) - FW'({1'b0, fifo_level})
                      + (hold_full_q ? FW'(0) : FW'(1));

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        pend_last_d = 1'b0;
        xfer_done_d = 1'b0;
        xfer_len_d  = xfer_len_q;
        push        = 1'b0;
        push_data   = {1'b0, hold_q};

        case (state_q)
            S_IDLE: if (!m_addr_n && (m_wrdn == WRDN_READ)) state_d = S_ADDR;
            S_ADDR: if (m_data) state_d = S_DATA;
            S_DATA: if (m_data_fell) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Deferred last-word push after a capture collided with the end of transaction.
        // The FSM is idle in this cycle, so no capture can compete for the push port.
        if (pend_last_q && hold_full_q) begin
            push        = 1'b1;
            push_data   = {1'b1, hold_q};
            hold_full_d = 1'b0;
        end

        if (capture) begin
            push        = hold_full_q;
            push_data   = {1'b0, hold_q};
            hold_d      = adio_out;
            hold_full_d = 1'b1;
            cnt_d       = sat_inc(cnt_q);
        end

        if (end_xfer) begin
            xfer_done_d = 1'b1;
            xfer_len_d  = capture ? sat_inc(cnt_q) : cnt_q;
            cnt_d       = '0;
            if (capture) begin
                pend_last_d = 1'b1;
            end else if (hold_full_q) begin
                push        = 1'b1;
                push_data   = {1'b1, hold_q};
                hold_full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            m_dataq_q   <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            pend_last_q <= 1'b0;
            m_ready_q   <= 1'b0;
            xfer_done_q <= 1'b0;
            xfer_len_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_dataq_q   <= m_data;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            pend_last_q <= pend_last_d;
            m_ready_q   <= (free_slots > FW'(AF_MARGIN));
            xfer_done_q <= xfer_done_d;
            xfer_len_q  <= xfer_len_d;
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    sink_fifo #(
        .ADDR_LENGTH(ADDR_LENGTH)
    ) u_fifo (
        .clk_i       (CLK),
        .resetn_i    (reset_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .level_o     (fifo_level)
    );

    assign rd_valid  = ~fifo_empty;
    assign pop       = rd_valid & rd_ready;
    // Storage is not reset, so the stream fields are forced to zero while empty.
    assign rd_data   = fifo_empty ? 32'd0 : fifo_data[31:0];
    assign rd_last   = fifo_empty ? 1'b0 : fifo_data[32];
    assign level     = fifo_level;
    assign m_ready   = m_ready_q;
    assign xfer_done = xfer_done_q;
    assign xfer_len  = xfer_len_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_master_read_sink.sv
// tb/tb_master_read_sink.sv - directed self-checking bench for master_read_sink
module tb_master_read_sink;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] adio_out = '0;
    logic        m_data = 1'b0;
    logic        m_data_vld = 1'b0;
    logic        m_addr_n = 1'b1;
    logic        m_wrdn = 1'b1;
    logic        m_ready;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [5:0]  level;
    logic        xfer_done;
    logic [15:0] xfer_len;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    logic [32:0] rxq[$];
    int          done_cnt = 0;
    logic [15:0] last_len = '0;

    master_read_sink #(.ADDR_LENGTH(5), .AF_MARGIN(4)) dut (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .adio_out   (adio_out),
        .m_data     (m_data),
        .m_data_vld (m_data_vld),
        .m_addr_n   (m_addr_n),
        .m_wrdn     (m_wrdn),
        .m_ready    (m_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .level      (level),
        .xfer_done  (xfer_done),
        .xfer_len   (xfer_len),
        .overflow   (overflow)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (reset_n && rd_valid && rd_ready) rxq.push_back({rd_last, rd_data});
        if (xfer_done) begin
            done_cnt++;
            last_len = xfer_len;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One read/write transaction: address cycle, one m_data cycle without data, then n
    // words (optionally only while m_ready is high), then m_data falls.
    task automatic run_xfer(input int n, input logic [31:0] base, input bit honour,
                            input bit wr, input bit release_on_stall, output bit vld_in_fall);
        int  sent = 0;
        int  stall = 0;
        int  guard = 0;
        bit  released = 0;
        bit  v;
        m_addr_n = 1'b0;
        m_wrdn   = wr;
        step();
        m_addr_n = 1'b1;
        m_wrdn   = 1'b1;
        m_data   = 1'b1;
        step();
        while (sent < n && guard < 3000) begin
            if (release_on_stall && !released && stall == 8) begin
                check_eq("bp_m_ready_low", m_ready, 0);
                check_eq("bp_level_stall", level, 29);
                check_eq("bp_no_overflow", overflow, 0);
                rd_ready = 1'b1;
                released = 1;
            end
            v = honour ? m_ready : 1'b1;
            m_data_vld = v;
            adio_out   = base + sent;
            if (v) sent++;
            stall = m_ready ? 0 : stall + 1;
            step();
            guard++;
        end
        check_eq("xfer_words_sent", sent, n);
        m_data_vld = 1'b0;
        m_data     = 1'b0;
        vld_in_fall = rd_valid;
        step();
    endtask

    task automatic check_stream(input string tag, input int n, input logic [31:0] base,
                                input bit last_on_final);
        check_eq({tag, "_count"}, rxq.size(), n);
        for (int i = 0; i < n && i < rxq.size(); i++) begin
            check_eq({tag, "_data"}, rxq[i][31:0], base + i);
            check_eq({tag, "_last"}, rxq[i][32], (last_on_final && i == n - 1) ? 1 : 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit vf;
        int d0;

        // Reset state
        reset_n = 1'b0;
        step(3);
        check_eq("rst_m_ready", m_ready, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_rd_last", rd_last, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_xfer_done", xfer_done, 0);
        check_eq("rst_xfer_len", xfer_len, 0);
        check_eq("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        step();
        check_eq("m_ready_after_rst", m_ready, 1);

        // Single read, downstream stalled
        rxq.delete();
        run_xfer(1, 32'hDEADBEEF, 1, 0, 0, vf);
        check_eq("single_valid_in_fall", vf, 0);
        check_eq("single_rd_valid", rd_valid, 1);
        check_eq("single_rd_data", rd_data, 32'hDEADBEEF);
        check_eq("single_rd_last", rd_last, 1);
        check_eq("single_xfer_done", xfer_done, 1);
        check_eq("single_xfer_len", xfer_len, 1);
        step();
        check_eq("single_done_pulse", xfer_done, 0);
        check_eq("single_len_held", xfer_len, 1);
        check_eq("single_stable_data", rd_data, 32'hDEADBEEF);
        rd_ready = 1'b1;
        step(2);
        check_eq("single_level", level, 0);
        check_stream("single", 1, 32'hDEADBEEF, 1);

        // 8-word burst with free-flowing downstream
        rxq.delete();
        d0 = done_cnt;
        run_xfer(8, 32'h100, 1, 0, 0, vf);
        step(3);
        check_stream("burst", 8, 32'h100, 1);
        check_eq("burst_len", last_len, 8);
        check_eq("burst_done_cnt", done_cnt - d0, 1);
        check_eq("burst_level", level, 0);

        // Backpressure: 40 words, core honours m_ready
        rxq.delete();
        rd_ready = 1'b0;
        run_xfer(40, 32'h1000, 1, 0, 1, vf);
        step(45);
        check_stream("bp", 40, 32'h1000, 1);
        check_eq("bp_len", last_len, 40);
        check_eq("bp_overflow", overflow, 0);
        check_eq("bp_m_ready_back", m_ready, 1);
        check_eq("bp_level_end", level, 0);

        // Write transaction ignored
        rxq.delete();
        d0 = done_cnt;
        run_xfer(4, 32'h200, 0, 1, 0, vf);
        step(3);
        check_eq("wr_no_done", done_cnt - d0, 0);
        check_eq("wr_no_data", rxq.size(), 0);
        check_eq("wr_level", level, 0);

        // Zero-data read
        run_xfer(0, 32'h0, 1, 0, 0, vf);
        check_eq("zero_xfer_done", xfer_done, 1);
        check_eq("zero_xfer_len", xfer_len, 0);
        step(3);
        check_eq("zero_no_data", rxq.size(), 0);

        // Overflow: 34 words ignoring m_ready with downstream stalled
        rxq.delete();
        rd_ready = 1'b0;
        d0 = done_cnt;
        run_xfer(34, 32'h300, 0, 0, 0, vf);
        check_eq("ovf_xfer_done", xfer_done, 1);
        check_eq("ovf_xfer_len", xfer_len, 34);
        check_eq("ovf_flag", overflow, 1);
        check_eq("ovf_level", level, 32);
        rd_ready = 1'b1;
        step(40);
        check_stream("ovf", 32, 32'h300, 0);
        check_eq("ovf_sticky", overflow, 1);
        check_eq("ovf_done_cnt", done_cnt - d0, 1);

        // Reset mid-burst after 3 words
        rxq.delete();
        rd_ready = 1'b0;
        d0 = done_cnt;
        m_addr_n = 1'b0;
        m_wrdn   = 1'b0;
        step();
        m_addr_n = 1'b1;
        m_wrdn   = 1'b1;
        m_data   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_data_vld = 1'b1;
            adio_out   = 32'h400 + i;
            step();
        end
        m_data_vld = 1'b0;
        check_eq("mid_level_before", level, 2);
        reset_n = 1'b0;
        step();
        check_eq("mid_m_ready", m_ready, 0);
        check_eq("mid_level", level, 0);
        check_eq("mid_rd_valid", rd_valid, 0);
        check_eq("mid_xfer_done", xfer_done, 0);
        check_eq("mid_overflow", overflow, 0);
        m_data  = 1'b0;
        reset_n = 1'b1;
        step(3);
        check_eq("mid_no_done", done_cnt - d0, 0);
        check_eq("mid_level_after", level, 0);

        // Following single read is captured correctly
        rd_ready = 1'b1;
        run_xfer(1, 32'h0BADF00D, 1, 0, 0, vf);
        step(3);
        check_stream("post", 1, 32'h0BADF00D, 1);
        check_eq("post_len", last_len, 1);
        check_eq("post_done_cnt", done_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
